// File: rtl/bs_pkg.sv
// Shared defaults, state encoding and direction constants for the rotate
// command stage and its combinational rotate core.
package bs_pkg;

    localparam int DATA_W = 4;
    localparam int K_W    = 2;
    localparam int CNT_W  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/bs_rotate_seq_if.sv
// Command and result stream bundle for bs_rotate_seq.
// The slave modport is the stage itself; the master modport is its environment.
interface bs_rotate_seq_if #(
    parameter int DATA_W = bs_pkg::DATA_W,
    parameter int K_W    = bs_pkg::K_W,
    parameter int CNT_W  = bs_pkg::CNT_W
);
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic [K_W-1:0]    i_k;
    logic              i_left;
    logic [CNT_W-1:0]  i_cnt;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic [CNT_W-1:0]  o_idx;
    logic              o_last;
    logic              o_busy;

    modport slave (
        input  i_valid, i_data, i_k, i_left, i_cnt, i_ready,
        output o_ready, o_valid, o_data, o_idx, o_last, o_busy
    );

    modport master (
        output i_valid, i_data, i_k, i_left, i_cnt, i_ready,
        input  o_ready, o_valid, o_data, o_idx, o_last, o_busy
    );
endinterface

// File: rtl/bs_rot_core.sv
// Combinational rotate of a DATA_W-bit word by k places, left or right.
// The word is doubled so a plain shift yields the wrapped bits directly.
module bs_rot_core #(
    parameter int DATA_W = bs_pkg::DATA_W,
    parameter int K_W    = bs_pkg::K_W
) (
    input  logic [DATA_W-1:0] src,
    input  logic [K_W-1:0]    k,
    input  logic              left,
    output logic [DATA_W-1:0] result
);
    import bs_pkg::*;

    logic [2*DATA_W-1:0] doubled;
    logic [2*DATA_W-1:0] shl;
    logic [2*DATA_W-1:0] shr;

    always_comb begin
        doubled = {src, src};
        shl     = doubled << k;
        shr     = doubled >> k;
        result  = (left == DIR_LEFT) ? shl[2*DATA_W-1:DATA_W] : shr[DATA_W-1:0];
    end
endmodule

// File: rtl/bs_rotate_seq.sv
// Accepts one rotate command and emits N beats, each the previous word
// rotated again by k, over a valid/ready stream with a last-beat flag.
module bs_rotate_seq
    import bs_pkg::*;
#(
    parameter int DATA_W = bs_pkg::DATA_W,
    parameter int K_W    = bs_pkg::K_W,
    parameter int CNT_W  = bs_pkg::CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    bs_rotate_seq_if.slave   bus
);
    state_t            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              left_q, left_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    logic [DATA_W-1:0] rot_src;
    logic [K_W-1:0]    rot_k;
    logic              rot_left;
    logic [DATA_W-1:0] rot_out;
    logic [CNT_W-1:0]  idx_next;

    // The single rotator sees the incoming command in IDLE and feeds back its own output in RUN.
    assign rot_src  = (state_q == ST_IDLE) ? bus.i_data : data_q;
    assign rot_k    = (state_q == ST_IDLE) ? bus.i_k    : k_q;
    assign rot_left = (state_q == ST_IDLE) ? bus.i_left : left_q;
    assign idx_next = idx_q + CNT_W'(1);

    bs_rot_core #(.DATA_W(DATA_W), .K_W(K_W)) u_rot (
        .src    (rot_src),
        .k      (rot_k),
        .left   (rot_left),
        .result (rot_out)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        left_d  = left_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                // A zero-count command is consumed without leaving IDLE.
                if (bus.i_valid && (bus.i_cnt != '0)) begin
                    k_d     = bus.i_k;
                    left_d  = bus.i_left;
                    cnt_d   = bus.i_cnt;
                    data_d  = rot_out;
                    idx_d   = CNT_W'(1);
                    valid_d = 1'b1;
                    last_d  = (bus.i_cnt == CNT_W'(1));
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (valid_q && bus.i_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        data_d = rot_out;
                        idx_d  = idx_next;
                        last_d = (idx_next == cnt_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            left_q  <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.o_ready = (state_q == ST_IDLE);
    assign bus.o_busy  = (state_q == ST_RUN);
    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_idx   = idx_q;
    assign bus.o_last  = last_q;
endmodule

// File: tb/tb_bs_rotate_seq.sv
// Directed bench for bs_rotate_seq: bursts, backpressure, zero-count,
// ignored commands, full-count burst and mid-burst reset.
module tb_bs_rotate_seq;
    import bs_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst;
    int   checks   = 0;
    int   failures = 0;

    bs_rotate_seq_if bus ();

    bs_rotate_seq dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_beat(input string tag, input logic [3:0] data, input int idx, input logic last);
        check_output({tag, " valid"}, 32'(bus.o_valid), 32'd1);
        check_output({tag, " data"},  32'(bus.o_data),  32'(data));
        check_output({tag, " idx"},   32'(bus.o_idx),   32'(idx));
        check_output({tag, " last"},  32'(bus.o_last),  32'(last));
        check_output({tag, " busy"},  32'(bus.o_busy),  32'd1);
        check_output({tag, " ready"}, 32'(bus.o_ready), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, " valid"}, 32'(bus.o_valid), 32'd0);
        check_output({tag, " ready"}, 32'(bus.o_ready), 32'd1);
        check_output({tag, " busy"},  32'(bus.o_busy),  32'd0);
        check_output({tag, " last"},  32'(bus.o_last),  32'd0);
    endtask

    // Presents a command for exactly one edge; returns at the negedge after acceptance.
    task automatic apply_stimulus(input logic [3:0] data, input logic [1:0] k, input logic left, input logic [3:0] cnt);
        bus.i_valid = 1'b1;
        bus.i_data  = data;
        bus.i_k     = k;
        bus.i_left  = left;
        bus.i_cnt   = cnt;
        tick();
        bus.i_valid = 1'b0;
        bus.i_data  = 4'hF;
        bus.i_k     = 2'd3;
        bus.i_left  = ~left;
        bus.i_cnt   = 4'd7;
    endtask

    initial begin
        logic [3:0] rot_l1 [4];
        rot_l1 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        i_rst       = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_k     = '0;
        bus.i_left  = 1'b0;
        bus.i_cnt   = '0;
        bus.i_ready = 1'b1;
        tick();
        tick();
        check_idle("reset");
        check_output("reset data", 32'(bus.o_data), 32'd0);
        check_output("reset idx",  32'(bus.o_idx),  32'd0);
        i_rst = 1'b0;
        tick();

        // Left by 1, four beats, no backpressure.
        apply_stimulus(4'b1001, 2'd1, DIR_LEFT, 4'd4);
        check_beat("t1 b1", 4'b0011, 1, 1'b0); tick();
        check_beat("t1 b2", 4'b0110, 2, 1'b0); tick();
        check_beat("t1 b3", 4'b1100, 3, 1'b0); tick();
        check_beat("t1 b4", 4'b1001, 4, 1'b1); tick();
        check_idle("t1 end");
        check_output("t1 hold data", 32'(bus.o_data), 32'b1001);
        check_output("t1 hold idx",  32'(bus.o_idx),  32'd4);

        // Right by 1, three beats.
        apply_stimulus(4'b1000, 2'd1, DIR_RIGHT, 4'd3);
        check_beat("t2 b1", 4'b0100, 1, 1'b0); tick();
        check_beat("t2 b2", 4'b0010, 2, 1'b0); tick();
        check_beat("t2 b3", 4'b0001, 3, 1'b1); tick();
        check_idle("t2 end");

        // Backpressure for three edges while beat 2 is presented.
        apply_stimulus(4'b1001, 2'd1, DIR_LEFT, 4'd4);
        check_beat("t3 b1", 4'b0011, 1, 1'b0); tick();
        check_beat("t3 b2", 4'b0110, 2, 1'b0);
        bus.i_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check_beat("t3 stall", 4'b0110, 2, 1'b0);
        end
        bus.i_ready = 1'b1;
        tick();
        check_beat("t3 b3", 4'b1100, 3, 1'b0); tick();
        check_beat("t3 b4", 4'b1001, 4, 1'b1); tick();
        check_idle("t3 end");

        // Zero count is consumed silently, then k=0 pass-through and left by 2.
        apply_stimulus(4'b0101, 2'd1, DIR_LEFT, 4'd0);
        check_idle("t4 cnt0 a"); tick();
        check_idle("t4 cnt0 b");
        apply_stimulus(4'b1010, 2'd0, DIR_LEFT, 4'd2);
        check_beat("t4 k0 b1", 4'b1010, 1, 1'b0); tick();
        check_beat("t4 k0 b2", 4'b1010, 2, 1'b1); tick();
        check_idle("t4 k0 end");
        apply_stimulus(4'b1100, 2'd2, DIR_LEFT, 4'd2);
        check_beat("t4 k2 b1", 4'b0011, 1, 1'b0); tick();
        check_beat("t4 k2 b2", 4'b1100, 2, 1'b1); tick();
        check_idle("t4 k2 end");

        // A command held valid during a burst must be ignored.
        apply_stimulus(4'b0001, 2'd1, DIR_LEFT, 4'd3);
        bus.i_valid = 1'b1;
        bus.i_data  = 4'b1111;
        bus.i_cnt   = 4'd1;
        check_beat("t5 b1", 4'b0010, 1, 1'b0); tick();
        check_beat("t5 b2", 4'b0100, 2, 1'b0); tick();
        check_beat("t5 b3", 4'b1000, 3, 1'b1);
        bus.i_valid = 1'b0;
        tick();
        check_idle("t5 end");

        // Full-count burst must reach idx 15 without wrapping.
        apply_stimulus(4'b0001, 2'd1, DIR_LEFT, 4'd15);
        for (int b = 1; b <= 15; b++) begin
            check_beat("full", rot_l1[(b - 1) % 4], b, (b == 15));
            tick();
        end
        check_idle("full end");

        // Reset during beat 2 aborts the burst.
        apply_stimulus(4'b1001, 2'd1, DIR_LEFT, 4'd5);
        check_beat("t6 b1", 4'b0011, 1, 1'b0); tick();
        check_beat("t6 b2", 4'b0110, 2, 1'b0);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_idle("t6 rst");
        check_output("t6 rst data", 32'(bus.o_data), 32'd0);
        check_output("t6 rst idx",  32'(bus.o_idx),  32'd0);
        apply_stimulus(4'b0110, 2'd3, DIR_RIGHT, 4'd1);
        check_beat("t6 new", 4'b1100, 1, 1'b1); tick();
        check_idle("t6 end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
